// File: rtl/revo_marker_decoder_pkg.sv
// revo_marker_decoder shared types and constants.
// Shared with the clock509/revo generator side.
package revo_marker_decoder_pkg;

    localparam int WORD_W           = 8;
    localparam int PHASE_W          = 11;
    localparam int DEF_PERIOD_WORDS = 1280;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/revo_marker_decoder_if.sv
// revo_marker_decoder word/status bundle.
// master drives the word stream, slave is the decoder.
interface revo_marker_decoder_if #(
    parameter int COUNTER_WIDTH = 16
);
    import revo_marker_decoder_pkg::*;

    logic [WORD_W-1:0]        revo_word_in;
    logic                     clear_counters;
    logic                     revo_pulse;
    logic                     locked;
    logic [2:0]               bit_phase;
    logic [PHASE_W-1:0]       word_phase;
    logic [COUNTER_WIDTH-1:0] miss_count;
    logic [COUNTER_WIDTH-1:0] spurious_count;
    logic [1:0]               state_out;

    modport master (
        output revo_word_in,
        output clear_counters,
        input  revo_pulse,
        input  locked,
        input  bit_phase,
        input  word_phase,
        input  miss_count,
        input  spurious_count,
        input  state_out
    );

    modport slave (
        input  revo_word_in,
        input  clear_counters,
        output revo_pulse,
        output locked,
        output bit_phase,
        output word_phase,
        output miss_count,
        output spurious_count,
        output state_out
    );

endinterface

// File: rtl/revo_marker_decoder_edge_finder.sv
// revo_edge_finder: input register, previous word, and
// priority encoder for the first rising marker edge.
module revo_edge_finder
    import revo_marker_decoder_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] word_in,
    output logic              edge_valid,
    output logic [2:0]        edge_phase
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] prev_word;
    logic [WORD_W:0]   seq;
    logic [WORD_W-1:0] rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q    <= '0;
            prev_word <= '0;
        end else begin
            word_q    <= word_in;
            prev_word <= word_q;
        end
    end

    // seq[8] is the last bit of the older word, so bit 7 sees it as predecessor
    assign seq  = {prev_word[0], word_q};
    assign rise = seq[WORD_W-1:0] & ~seq[WORD_W:1];

    always_comb begin
        edge_valid = |rise;
        edge_phase = '0;
        for (int k = 0; k < WORD_W; k++) begin
            if (rise[k]) edge_phase = 3'(WORD_W - 1 - k);
        end
    end

endmodule

// File: rtl/revo_marker_decoder.sv
// Revo marker decoder: edge find, flywheel lock, statistics.
// Optional: REVO_MARKER_DECODER_FLYWHEEL_EN pulses on every expected slot.
module revo_marker_decoder
    import revo_marker_decoder_pkg::*;
#(
    parameter int PERIOD_WORDS  = DEF_PERIOD_WORDS,
    parameter int LOCK_COUNT    = 4,
    parameter int MISS_LIMIT    = 2,
    parameter int COUNTER_WIDTH = 16
)(
    input logic                 clock,
    input logic                 reset_n,
    revo_marker_decoder_if.slave bus
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int RW = $clog2(MISS_LIMIT + 1);
    localparam int CW = COUNTER_WIDTH;

    logic         edge_valid;
    logic [2:0]   edge_phase;

    state_t               state_q, state_d;
    logic [2:0]           ref_q, ref_d;
    logic [PHASE_W-1:0]   wp_q, wp_d;
    logic [GW-1:0]        good_q, good_d, good_inc;
    logic [RW-1:0]        run_q, run_d, run_inc;
    logic [CW-1:0]        miss_q, miss_d;
    logic [CW-1:0]        spur_q, spur_d;
    logic                 pulse_q, pulse_d;
    logic                 locked_q, locked_d;
    logic [2:0]           bp_q, bp_d;
    logic                 at_slot;
    logic                 phase_match;

    revo_edge_finder u_edge (
        .clock      (clock),
        .reset_n    (reset_n),
        .word_in    (bus.revo_word_in),
        .edge_valid (edge_valid),
        .edge_phase (edge_phase)
    );

    assign at_slot     = (wp_q == PHASE_W'(PERIOD_WORDS - 1));
    assign phase_match = (edge_phase == ref_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            ref_q    <= '0;
            wp_q     <= '0;
            good_q   <= '0;
            run_q    <= '0;
            miss_q   <= '0;
            spur_q   <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
            bp_q     <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            wp_q     <= wp_d;
            good_q   <= good_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            spur_q   <= spur_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
            bp_q     <= bp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        wp_d     = wp_q;
        good_d   = good_q;
        run_d    = run_q;
        miss_d   = miss_q;
        spur_d   = spur_q;
        pulse_d  = 1'b0;
        locked_d = locked_q;
        bp_d     = bp_q;
        good_inc = good_q + 1'b1;
        run_inc  = run_q + 1'b1;
        unique case (state_q)
            SEARCH: begin
                wp_d = '0;
                if (edge_valid) begin
                    ref_d   = edge_phase;
                    good_d  = GW'(1);
                    pulse_d = 1'b1;
                    bp_d    = edge_phase;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                wp_d = wp_q + 1'b1;
                if (edge_valid) begin
                    pulse_d = 1'b1;
                    bp_d    = edge_phase;
                    wp_d    = '0;
                    if (at_slot && phase_match) begin
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        ref_d  = edge_phase;
                        good_d = GW'(1);
                    end
                end else if (at_slot) begin
                    wp_d    = '0;
                    state_d = SEARCH;
                end
            end
            LOCKED: begin
                wp_d = wp_q + 1'b1;
                if (at_slot) begin
                    wp_d = '0;
                    if (edge_valid && phase_match) begin
                        run_d   = '0;
                        pulse_d = 1'b1;
                        bp_d    = edge_phase;
                    end else begin
                        run_d  = run_inc;
                        miss_d = (&miss_q) ? miss_q : miss_q + 1'b1;
`ifdef REVO_MARKER_DECODER_FLYWHEEL_EN
                        pulse_d = 1'b1;
`else
                        pulse_d = 1'b0;
`endif
                        if (run_inc == RW'(MISS_LIMIT)) begin
                            run_d    = '0;
                            locked_d = 1'b0;
                            state_d  = SEARCH;
                        end
                    end
                end else if (edge_valid) begin
                    spur_d = (&spur_q) ? spur_q : spur_q + 1'b1;
                end
            end
            default: begin
                locked_d = 1'b0;
                state_d  = SEARCH;
            end
        endcase
        if (bus.clear_counters) begin
            miss_d = '0;
            spur_d = '0;
        end
    end

    assign bus.revo_pulse     = pulse_q;
    assign bus.locked         = locked_q;
    assign bus.bit_phase      = bp_q;
    assign bus.word_phase     = wp_q;
    assign bus.miss_count     = miss_q;
    assign bus.spurious_count = spur_q;
    assign bus.state_out      = state_q;

endmodule

// File: tb/tb_revo_marker_decoder.sv
// Self-checking bench for revo_marker_decoder against a
// time-based behavioural model plus directed literal checks.
module tb_revo_marker_decoder;

    localparam int P    = 1280;
    localparam int LOCK = 4;
    localparam int ML   = 2;
    localparam int CW   = 8;
    localparam int SAT  = (1 << CW) - 1;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    bit   chk_en;

    revo_marker_decoder_if #(.COUNTER_WIDTH(CW)) bus ();

    revo_marker_decoder #(
        .PERIOD_WORDS  (P),
        .LOCK_COUNT    (LOCK),
        .MISS_LIMIT    (ML),
        .COUNTER_WIDTH (CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // model state: st 0/1/2, times are model step numbers
    int         m_st, m_ref, m_rph, m_good, m_run;
    int         m_miss, m_spur, m_bp, m_pulse, m_cyc;
    logic [7:0] m_w, m_p;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s: got %0d want %0d at %0t",
                         nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ref = 0; m_rph = 0; m_good = 0; m_run = 0;
        m_miss = 0; m_spur = 0; m_bp = 0; m_pulse = 0; m_cyc = 0;
        m_w = '0; m_p = '0;
    endtask

    task automatic model_step(input logic [7:0] w, input logic clr);
        logic [8:0] sq;
        bit e;
        int ph;
        int since;
        m_cyc++;
        sq = {m_p[0], m_w};
        e  = 0;
        ph = 0;
        for (int k = 7; k >= 0; k--) begin
            if (!e && sq[k] && !sq[k+1]) begin
                e  = 1;
                ph = 7 - k;
            end
        end
        since   = m_cyc - m_ref;
        m_pulse = 0;
        if (m_st == 0) begin
            if (e) begin
                m_ref = m_cyc; m_rph = ph; m_good = 1;
                m_st = 1; m_pulse = 1; m_bp = ph;
            end
        end else if (m_st == 1) begin
            if (e) begin
                m_pulse = 1; m_bp = ph;
                if (since == P && ph == m_rph) begin
                    m_good++;
                    if (m_good == LOCK) m_st = 2;
                end else begin
                    m_rph = ph; m_good = 1;
                end
                m_ref = m_cyc;
            end else if (since == P) begin
                m_st = 0;
            end
        end else begin
            if (since == P) begin
                m_ref = m_cyc;
                if (e && ph == m_rph) begin
                    m_run = 0; m_pulse = 1; m_bp = ph;
                end else begin
                    m_run++;
                    if (m_miss < SAT) m_miss++;
`ifdef REVO_MARKER_DECODER_FLYWHEEL_EN
                    m_pulse = 1;
`endif
                    if (m_run == ML) begin
                        m_run = 0; m_st = 0;
                    end
                end
            end else if (e) begin
                if (m_spur < SAT) m_spur++;
            end
        end
        if (clr) begin
            m_miss = 0; m_spur = 0;
        end
        m_p = m_w;
        m_w = w;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("pulse", 32'(bus.revo_pulse), 32'(m_pulse));
            chk("locked", 32'(bus.locked), 32'(m_st == 2));
            chk("state", 32'(bus.state_out), 32'(m_st));
            chk("bit_phase", 32'(bus.bit_phase), 32'(m_bp));
            chk("miss", 32'(bus.miss_count), 32'(m_miss));
            chk("spur", 32'(bus.spurious_count), 32'(m_spur));
            if (m_st == 2)
                chk("word_phase", 32'(bus.word_phase),
                    32'(m_cyc - m_ref));
        end
    end

    task automatic cyc(input logic [7:0] w, input logic clr);
        @(negedge clock);
        bus.revo_word_in   = w;
        bus.clear_counters = clr;
        @(posedge clock);
        if (reset_n) model_step(w, clr);
    endtask

    task automatic period(input logic [7:0] m0, input logic [7:0] m1,
                          input int xs, input logic [7:0] xw,
                          input int clr_slot);
        logic [7:0] w;
        for (int s = 0; s < P; s++) begin
            w = 8'h00;
            if (s == 0) w = m0;
            else if (s == 1) w = m1;
            else if (s == xs) w = xw;
            cyc(w, s == clr_slot);
        end
    endtask

    task automatic mark(input logic [7:0] m0);
        period(m0, 8'h00, -1, 8'h00, -1);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n            = 1'b1;
        bus.revo_word_in   = 8'h00;
        bus.clear_counters = 1'b0;
        @(posedge clock);
        model_step(8'h00, 1'b0);
    endtask

    task automatic lit(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        #1 chk(nm, act, exp);
    endtask

    initial begin
        logic [7:0] mk, w;
        int r, k0;
        total = 0;
        bad   = 0;
        chk_en = 1'b1;
        reset_n = 1'b0;
        bus.revo_word_in   = 8'h00;
        bus.clear_counters = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        lit("rst_locked", 32'(bus.locked), 0);
        lit("rst_state", 32'(bus.state_out), 0);
        lit("rst_pulse", 32'(bus.revo_pulse), 0);
        lit("rst_miss", 32'(bus.miss_count), 0);
        release_reset();

        repeat (3) mark(8'hFF);
        lit("a_not_locked", 32'(bus.locked), 0);
        lit("a_verify", 32'(bus.state_out), 1);
        mark(8'hFF);
        lit("a_locked", 32'(bus.locked), 1);
        lit("a_state", 32'(bus.state_out), 2);
        lit("a_bp", 32'(bus.bit_phase), 0);

        mark(8'h00);
        lit("b_miss1", 32'(bus.miss_count), 1);
        lit("b_hold", 32'(bus.locked), 1);
        mark(8'hFF);
        mark(8'h00);
        mark(8'h00);
        lit("b_drop", 32'(bus.locked), 0);
        lit("b_search", 32'(bus.state_out), 0);
        lit("b_miss3", 32'(bus.miss_count), 3);

        repeat (4) mark(8'hFF);
        period(8'hFF, 8'h00, 600, 8'hFF, -1);
        mark(8'hFF);
        lit("c_spur1", 32'(bus.spurious_count), 1);
        lit("c_locked", 32'(bus.locked), 1);
        lit("c_miss", 32'(bus.miss_count), 3);
        for (int s = 0; s < P; s++) begin
            w = 8'h00;
            if (s == 0) w = 8'hFF;
            else if (s >= 100 && s < 700 && (s % 2) == 1) w = 8'hFF;
            cyc(w, 1'b0);
        end
        lit("c_spur_sat", 32'(bus.spurious_count), SAT);

        period(8'h00, 8'h00, -1, 8'h00, 1);
        lit("d_clr_miss", 32'(bus.miss_count), 0);
        lit("d_clr_spur", 32'(bus.spurious_count), 0);
        lit("d_locked", 32'(bus.locked), 1);
        mark(8'hFF);

        cyc(8'hFF, 1'b0);
        repeat (599) cyc(8'h00, 1'b0);
        do_reset();
        lit("e_pulse", 32'(bus.revo_pulse), 0);
        lit("e_locked", 32'(bus.locked), 0);
        lit("e_wp", 32'(bus.word_phase), 0);
        lit("e_miss", 32'(bus.miss_count), 0);
        repeat (3) cyc(8'h00, 1'b0);
        release_reset();

        cyc(8'hFF, 1'b0);
        repeat (999) cyc(8'h00, 1'b0);
        repeat (3) mark(8'hFF);
        lit("f_not_locked", 32'(bus.locked), 0);
        lit("f_verify", 32'(bus.state_out), 1);
        mark(8'hFF);
        lit("f_locked", 32'(bus.locked), 1);

        do_reset();
        release_reset();
        repeat (4) period(8'h07, 8'hF8, -1, 8'h00, -1);
        lit("g_locked", 32'(bus.locked), 1);
        lit("g_bp5", 32'(bus.bit_phase), 5);

        repeat (3 * P) cyc(8'hFF, 1'b0);
        lit("h_decay", 32'(bus.locked), 0);
        lit("h_search", 32'(bus.state_out), 0);

        do_reset();
        release_reset();
        k0 = $urandom_range(0, 7);
        mk = 8'hFF >> (7 - k0);
        repeat (12) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                mark(8'h00);
            else if (r == 1)
                mark(8'hFF >> $urandom_range(0, 7));
            else if (r == 2)
                period(mk, 8'h00, $urandom_range(2, P - 1),
                       8'($urandom), -1);
            else if (r == 3)
                period(mk, 8'h00, -1, 8'h00, $urandom_range(0, P - 1));
            else
                mark(mk);
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/revo_marker_decoder.md
Name: revo_marker_decoder

Overview:
- Receive-side counterpart to the clock509/revo generator.
- Consumes the 8-bit deserialized revo word stream, one word per word clock, from an ISERDES/deserializer upstream.
- Finds the rising edge of the revolution marker and records its bit phase within the word.
- Flywheels onto the expected marker period, reports lock state, and counts missing and spurious markers for accelerator-timing firmware.

Parameters:
- PERIOD_WORDS, 1280: expected word clocks between marker edges.
- LOCK_COUNT, 4: consecutive on-time, same-phase edges required to enter LOCKED.
- MISS_LIMIT, 2: consecutive missing or wrong-phase expected edges that drop lock.
- COUNTER_WIDTH, 16: width of the saturating statistics counters.

Ports:
- clock  in  1  word clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- revo_word_in  in  8  deserialized revo word; bit 7 is oldest in time.
- clear_counters  in  1  synchronous; zeroes miss_count and spurious_count.
- revo_pulse  out  1  one-cycle marker strobe.
- locked  out  1  high while in the LOCKED state.
- bit_phase  out  3  bit offset of the marker edge; 0 means the edge is at bit 7.
- word_phase  out  11  words since the last reference edge; valid while locked.
- miss_count  out  COUNTER_WIDTH  saturating count of missed expected edges.
- spurious_count  out  COUNTER_WIDTH  saturating count of unexpected edges.
- state_out  out  2  debug copy of the FSM state.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state SEARCH, internal prev_word 0, all counters 0.
- Input stage: revo_word_in is registered; prev_word holds the previous registered word.
- Edge detect on the 9-bit sequence {prev_word[0], word[7:0]}:
  - Rising edge at bit k means word[k]=1 and the preceding bit is 0.
  - The preceding bit is word[k+1], or prev_word[0] when k=7.
  - The highest such k wins; edge_phase = 7-k.
  - At most one edge is reported per word; additional edges in the same word are ignored.
- Latency: revo_pulse, bit_phase and counter updates are registered and appear 2 clocks after the word containing the edge is presented.
- FSM encoding: SEARCH=0, VERIFY=1, LOCKED=2.
- SEARCH:
  - On an edge: ref_phase <= edge_phase, word_phase <= 0, good <= 1, go to VERIFY.
- VERIFY:
  - word_phase increments each clock.
  - Edge with word_phase==PERIOD_WORDS-1 and edge_phase==ref_phase: good++, word_phase <= 0.
  - If good reaches LOCK_COUNT, go to LOCKED, assert locked, and drive bit_phase <= ref_phase.
  - Edge at any other count, or with a different phase: restart VERIFY using this edge as the new reference (good=1, word_phase 0).
  - word_phase reaching PERIOD_WORDS-1 with no edge: go to SEARCH.
- LOCKED:
  - word_phase counts 0..PERIOD_WORDS-1 and wraps to 0 on the expected slot, whether or not an edge arrives.
  - Expected slot with a matching edge: miss_run <= 0, revo_pulse=1.
  - Expected slot with no edge or a wrong-phase edge: miss_run++ and miss_count++ (saturating).
  - miss_run reaching MISS_LIMIT: deassert locked and go to SEARCH on the same clock.
  - Edge at a non-expected slot: spurious_count++ (saturating), otherwise ignored; no resync while locked.
- revo_pulse in SEARCH and VERIFY: asserted on every detected edge.
- Counters saturate at all-ones; no wrap.
- clear_counters coinciding with an increment: clear wins and the result is 0.
- Marker spanning a word boundary (e.g. prev=00000111, word=11111000): the edge is reported in the earlier word with phase 5; the following word shows no edge.
- Constant-1 input produces no edges; locked decays after MISS_LIMIT periods.
- reset_n asserted mid-operation: immediate return to reset values.

Optional Feature:
- REVO_MARKER_DECODER_FLYWHEEL_EN defined:
  - While LOCKED, revo_pulse is asserted on every expected slot, including missed ones (miss counting is unchanged).
  - bit_phase holds its value.
- Undefined: revo_pulse is asserted only on actually detected matching edges.

Decomposition:
- Shared package/header holds:
  - State encodings SEARCH/VERIFY/LOCKED.
  - Default PERIOD_WORDS=1280 (shared with the generator).
  - Word width 8.
- One sub-module, revo_edge_finder: input register, prev_word, priority encoder; outputs edge_valid and edge_phase[2:0].

Test Plan:
- Markers 8'hFF every 1280 words after reset -> locked=1 on the 4th edge (3 verified periods); bit_phase=0; revo_pulse every 1280 clocks, 2 clocks after the marker word.
- Marker shifted to straddle words (00000111, 11111000) -> locks with bit_phase=5; the edge is flagged on the first word only.
- Once locked, omit one marker -> miss_count=1, locked stays 1. Omit two consecutive -> locked=0, state SEARCH, miss_count=2.
- Inject an extra 8'hFF at word_phase=600 while locked -> spurious_count=1, no resync, next expected pulse on time.
- In VERIFY, edge arrives at count 1000 -> good resets to 1 and lock needs 3 more exact periods from the new reference. Also drive clear_counters together with a miss -> counter reads 0.
- Pulse reset_n low mid-period while locked -> all outputs 0 immediately; relock after 4 markers. With REVO_MARKER_DECODER_FLYWHEEL_EN, a missed marker still yields revo_pulse.
